// File: rtl/gf_mul_seq.sv
`timescale 1ns/1ps
// gf_mul_seq: sequential GF(2^8) multiplier, reduction polynomial 0x11B.
//
// The block uses shift-and-add. Each RUN cycle consumes one multiplier bit,
// LSB first. When that bit is set, a_reg is XORed into the accumulator.
// a_reg is then multiplied by x (xtime) and b_reg is shifted right.
//
// Handshake rules, for both sides of the block:
//   A transfer happens on a rising edge where valid and ready are both high.
//   Input side (in_valid_i/in_ready_o): ready only in IDLE. Operands are
//   sampled once, on the accepting edge.
//   Output side (out_valid_o/out_ready_i): valid only in DONE. p_o stays
//   stable until the consumer accepts it. After the accept the block spends
//   at least one cycle in IDLE before it takes new operands.
//
// Configuration macro:
//   GF_MUL_EARLY_EXIT_EN  leave RUN as soon as the remaining multiplier
//                         bits are all zero. The product is the same as
//                         in the default build; only the latency changes.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   a_i, b_i     8-bit operands
//   in_valid_i   operands valid
//   in_ready_o   block can accept operands (IDLE)
//   p_o          product (equals the accumulator in every state)
//   out_valid_o  p_o valid (DONE)
//   out_ready_i  consumer accepts p_o
//   busy_o       high in RUN or DONE
module gf_mul_seq (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [7:0] p_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] a_xtime;
  logic       run_last;

  gf_xtime u_xtime (
    .x_i (a_q),
    .y_o (a_xtime)
  );

  // The current RUN cycle is the final iteration.
`ifdef GF_MUL_EARLY_EXIT_EN
  // Stop when no set multiplier bits remain after this shift. The cnt test
  // is redundant; it is kept as a hard bound on the number of iterations.
  assign run_last = ((b_q >> 1) == 8'h00) || (cnt_q == 4'd7);
`else
  assign run_last = (cnt_q == 4'd7);
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      acc_q   <= 8'h00;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid_i) state_d = ST_RUN;
      ST_RUN:  if (run_last)   state_d = ST_DONE;
      ST_DONE: if (out_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    acc_d = acc_q;
    a_d   = a_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          a_d   = a_i;
          b_d   = b_i;
          acc_d = 8'h00;
          cnt_d = 4'd0;
        end
      end
      ST_RUN: begin
        if (b_q[0]) acc_d = acc_q ^ a_q;
        a_d   = a_xtime;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 4'd1;
      end
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready_o  = (state_q == ST_IDLE);
    out_valid_o = (state_q == ST_DONE);
    busy_o      = (state_q != ST_IDLE);
    p_o         = acc_q;
  end

endmodule

// gf_xtime: multiply by x in GF(2^8) modulo 0x11B.
// Ports: x_i input byte, y_o = x_i * x.
module gf_xtime (
  input  logic [7:0] x_i,
  output logic [7:0] y_o
);
  // Shifting out bit 7 represents x^8, which reduces to 0x1B.
  assign y_o = {x_i[6:0], 1'b0} ^ (x_i[7] ? 8'h1B : 8'h00);
endmodule
